// File: rtl/special_op_ctrl_stage.sv
// Pipelined JAL/JALR/LUI/AUIPC selector with registered writeback,
// one-cycle jump redirect and wrong-path squash after each redirect.
module special_op_ctrl_stage #(
  parameter int XLEN = 32,
  parameter int FLUSH_CYCLES = 2,
  localparam int CNT_W =
    (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_sel,
  output logic [XLEN-1:0] out_val,
  output logic [4:0]      out_rd,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic            r_out_valid;
  logic [2:0]      r_out_sel;
  logic [XLEN-1:0] r_out_val;
  logic [4:0]      r_out_rd;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [4:0]      w_op;
  logic            w_is_jalr;
  logic            w_is_jal;
  logic            w_is_lui;
  logic            w_is_auipc;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_pc4;
  logic [2:0]      w_sel;
  logic [XLEN-1:0] w_val;
  logic            w_jump;
  logic [XLEN-1:0] w_tgt;
  logic            w_acc;
  logic            w_load;
  logic            w_drop;
  logic            w_unused;

  assign w_unused = &{1'b0, in_instr[1:0]};

  assign w_op       = in_instr[6:2];
  assign w_is_jalr  = (w_op == OP_JALR);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_is_lui   = (w_op == OP_LUI);
  assign w_is_auipc = (w_op == OP_AUIPC);

  assign w_imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_imm_i = XLEN'($signed(in_instr[31:20]));
  assign w_imm_j = XLEN'($signed({in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21],
                                  1'b0}));
  assign w_pc4   = in_pc + XLEN'(4);

  always_comb begin
    w_sel  = 3'b000;
    w_val  = '0;
    w_jump = 1'b0;
    w_tgt  = '0;
    unique case (1'b1)
      w_is_jalr: begin
        w_sel  = 3'b111;
        w_val  = w_pc4;
        w_jump = 1'b1;
        w_tgt  = (in_rs1 + w_imm_i) & ~XLEN'(1);
      end
      w_is_jal: begin
        w_sel  = 3'b110;
        w_val  = w_pc4;
        w_jump = 1'b1;
        w_tgt  = in_pc + w_imm_j;
      end
      w_is_lui: begin
        w_sel = 3'b100;
        w_val = w_imm_u;
      end
      w_is_auipc: begin
        w_sel = 3'b101;
        w_val = in_pc + w_imm_u;
      end
      default: ;
    endcase
  end

  // Squash beats are always accepted so fetch drains regardless of backpressure.
  assign in_ready = (r_state == S_FLUSH) || !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_load   = w_acc && (r_state == S_RUN);
  assign w_drop   = w_acc && (r_state == S_FLUSH);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_load && w_jump && (FLUSH_CYCLES > 0)) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        if (w_drop) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (kill) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_out_sel        <= '0;
      r_out_val        <= '0;
      r_out_rd         <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (kill) begin
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      r_redirect_valid <= w_load && w_jump;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_sel   <= w_sel;
        r_out_val   <= w_val;
        r_out_rd    <= in_instr[11:7];
        if (w_jump) r_redirect_pc <= w_tgt;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_sel        = r_out_sel;
  assign out_val        = r_out_val;
  assign out_rd         = r_out_rd;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_special_op_ctrl_stage.sv
// Bench for special_op_ctrl_stage: directed scenarios plus
// randomized traffic against a beat-level reference model.
module tb_special_op_ctrl_stage;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            kill;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_sel;
  logic [XLEN-1:0] out_val;
  logic [4:0]      out_rd;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_chk = 0;
  int n_err = 0;

  bit        m_ov;
  bit        m_rv;
  bit [2:0]  m_sel;
  bit [31:0] m_val;
  bit [31:0] m_rpc;
  bit [4:0]  m_rd;
  int        m_drop;

  always #5 clk = ~clk;

  special_op_ctrl_stage #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_val(out_val), .out_rd(out_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RV32I semantics written straight from the field definitions.
  function automatic void ref_op(
    input  bit [31:0] ins, input bit [31:0] pc, input bit [31:0] rs1,
    output bit [2:0] sel, output bit [31:0] val,
    output bit jmp, output bit [31:0] tgt);
    longint u, i, j;
    u = longint'(ins) & 64'hFFFF_F000;
    i = longint'(ins[31:20]);
    if (ins[31]) i -= 4096;
    j = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * (1 << 12)
      + longint'(ins[20]) * (1 << 11) + longint'(ins[30:21]) * 2;
    if (ins[31]) j -= (1 << 21);
    sel = 3'b000; val = 0; jmp = 0; tgt = 0;
    case (ins[6:2])
      5'b11001: begin
        sel = 3'b111; val = 32'(longint'(pc) + 4); jmp = 1;
        tgt = 32'(longint'(rs1) + i) & 32'hFFFF_FFFE;
      end
      5'b11011: begin
        sel = 3'b110; val = 32'(longint'(pc) + 4); jmp = 1;
        tgt = 32'(longint'(pc) + j);
      end
      5'b01101: begin sel = 3'b100; val = 32'(u); end
      5'b00101: begin sel = 3'b101; val = 32'(longint'(pc) + u); end
      default: ;
    endcase
  endfunction

  // Called at a negedge: drive one cycle, advance the model, compare at next negedge.
  task automatic step(bit rn, bit k, bit v, bit [31:0] ins,
                      bit [31:0] pc, bit [31:0] rs1, bit ordy);
    bit rdy, ld, dr, jp;
    bit [2:0] s;
    bit [31:0] vl, tg;
    rst_n = rn; kill = k; in_valid = v; in_instr = ins;
    in_pc = pc; in_rs1 = rs1; out_ready = ordy;
    #1;
    rdy = (m_drop > 0) || !m_ov || ordy;
    if (rn) check("in_ready", in_ready, rdy);
    ref_op(ins, pc, rs1, s, vl, jp, tg);
    if (!rn) begin
      m_ov = 0; m_rv = 0; m_sel = 0; m_val = 0;
      m_rd = 0; m_rpc = 0; m_drop = 0;
    end else if (k) begin
      m_ov = 0; m_rv = 0; m_drop = 0;
    end else begin
      ld = v && rdy && (m_drop == 0);
      dr = v && rdy && (m_drop > 0);
      m_rv = 0;
      if (m_ov && ordy) m_ov = 0;
      if (ld) begin
        m_ov = 1; m_sel = s; m_val = vl; m_rd = ins[11:7];
        if (jp) begin m_rv = 1; m_rpc = tg; m_drop = FC; end
      end
      if (dr) m_drop--;
    end
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("redirect_valid", redirect_valid, m_rv);
    if (m_ov || !rn) begin
      check("out_sel", out_sel, m_sel);
      check("out_val", out_val, m_val);
      check("out_rd", out_rd, m_rd);
    end
    if (m_rv || !rn) check("redirect_pc", redirect_pc, m_rpc);
  endtask

  localparam bit [31:0] I_LUI   = 32'h1234_50B7;
  localparam bit [31:0] I_AUIPC = 32'h0000_1097;
  localparam bit [31:0] I_JAL   = 32'h0100_00EF;
  localparam bit [31:0] I_JALR4 = 32'h0040_00E7;
  localparam bit [31:0] I_JALR2 = 32'h0020_00E7;
  localparam bit [31:0] I_ADD   = 32'h0020_81B3;

  initial begin
    bit [4:0] ops [5];
    bit [31:0] ins;
    ops = '{5'b11001, 5'b11011, 5'b01101, 5'b00101, 5'b01100};
    m_ov = 0; m_rv = 0; m_sel = 0; m_val = 0;
    m_rd = 0; m_rpc = 0; m_drop = 0;
    rst_n = 0; kill = 0; in_valid = 1; in_instr = I_JAL;
    in_pc = 0; in_rs1 = 0; out_ready = 1;
    @(negedge clk);

    repeat (3) step(0, 0, 1, I_JAL, 32'h200, 0, 1);
    check("rst_in_ready", in_ready, 1);

    step(1, 0, 1, I_LUI, 32'h0, 0, 1);
    check("lui_sel", out_sel, 3'b100);
    check("lui_val", out_val, 32'h1234_5000);
    check("lui_rd", out_rd, 5'd1);
    step(1, 0, 1, I_AUIPC, 32'h100, 0, 1);
    check("auipc_val", out_val, 32'h1100);

    step(1, 0, 1, I_JAL, 32'h200, 0, 1);
    check("jal_rv", redirect_valid, 1);
    check("jal_pc", redirect_pc, 32'h210);
    check("jal_val", out_val, 32'h204);
    step(1, 0, 0, I_ADD, 32'h204, 0, 1);
    check("jal_pulse", redirect_valid, 0);
    step(1, 0, 1, I_LUI, 32'h204, 0, 1);
    step(1, 0, 1, I_LUI, 32'h208, 0, 1);
    check("drop2_ov", out_valid, 0);
    step(1, 0, 1, I_AUIPC, 32'h300, 0, 1);
    check("third_val", out_val, 32'h1300);

    step(1, 0, 1, I_JALR4, 32'h400, 32'h1001, 1);
    check("jalr_pc", redirect_pc, 32'h1004);
    check("jalr_sel", out_sel, 3'b111);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, I_JALR2, 32'h500, 32'hFFFF_FFFF, 1);
    check("jalr_wrap", redirect_pc, 32'h0);
    step(1, 1, 0, 0, 0, 0, 1);

    step(1, 0, 1, I_ADD, 32'h600, 0, 0);
    check("add_sel", out_sel, 3'b000);
    repeat (5) begin
      step(1, 0, 1, I_LUI, 32'h604, 0, 0);
      check("bp_ready", in_ready, 0);
      check("bp_rd", out_rd, 5'd3);
    end
    step(1, 0, 1, I_LUI, 32'h604, 0, 1);
    step(1, 0, 1, I_AUIPC, 32'h0, 0, 1);
    check("b2b_ov", out_valid, 1);
    check("b2b_sel", out_sel, 3'b101);

    step(1, 0, 1, I_JAL, 32'h700, 0, 1);
    step(1, 0, 1, I_ADD, 32'h704, 0, 1);
    step(1, 1, 1, I_LUI, 32'h708, 0, 1);
    check("kill_ov", out_valid, 0);
    step(1, 0, 1, I_LUI, 32'h800, 0, 1);
    check("after_kill", out_valid, 1);
    step(0, 1, 1, I_JAL, 32'h900, 0, 1);
    check("rst_kill_ov", out_valid, 0);
    check("rst_kill_val", out_val, 0);

    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:2] = ops[$urandom_range(0, 4)];
      ins[1:0] = 2'b11;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
           $urandom_range(0, 3) != 0, ins, $urandom, $urandom,
           $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
